// File: rtl/uart_rx_fifo_wr.sv
// UART 8N1 receiver that writes each good byte straight into a downstream sync FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1 framing) and the parity_err flag.
module uart_rx_fifo_wr #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       fifo_full,
    input  logic       err_clr,
    output logic       fifo_wr,
    output logic [7:0] fifo_din,
    output logic       busy,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      din_q;
    logic            commit_q, commit_d;
    logic            sync1_q, rxs_q;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic            frame_set;

`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
    logic            par_set;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            din_q       <= '0;
            commit_q    <= 1'b0;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            commit_q    <= commit_d;
            sync1_q     <= rxd;
            rxs_q       <= sync1_q;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            if (fifo_wr) din_q <= shift_q;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        commit_d  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    cnt_d   = CNT_HALF;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        cnt_d   = CNT_FULL;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
                        par_bad_d = 1'b0;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_FULL;
                    state_d = S_STOP;
                    // Even parity: the parity bit makes the total count of ones even.
                    if (rxs_q != ^shift_q) begin
                        par_bad_d = 1'b1;
                        par_set   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        // Leave at the stop midpoint so a back-to-back start bit is caught.
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        commit_d = !par_bad_q;
`else
                        commit_d = 1'b1;
`endif
                    end else begin
                        state_d   = S_BREAK;
                        frame_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_BREAK: begin
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fifo_wr  = commit_q & ~fifo_full;
    assign fifo_din = fifo_wr ? shift_q : din_q;
    assign busy     = (state_q != S_IDLE);

    // Set beats clear when both happen in the same cycle.
    assign overrun_d   = (commit_q & fifo_full) | (overrun_q & ~err_clr);
    assign frame_err_d = frame_set | (frame_err_q & ~err_clr);
    assign overrun     = overrun_q;
    assign frame_err   = frame_err_q;

`ifdef UART_RX_PARITY_EN
    assign parity_err_d = par_set | (parity_err_q & ~err_clr);
    assign parity_err   = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Directed bench for uart_rx_fifo_wr at CLKS_PER_BIT=4, with a 16-deep FIFO occupancy model.
`timescale 1ns/1ps
module tb_uart_rx_fifo_wr;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       err_clr = 1'b0;
    logic       force_full = 1'b0;
    logic       use_real = 1'b0;
    logic       fcnt_clr = 1'b0;
    logic       fifo_full;
    logic       fifo_wr;
    logic [7:0] fifo_din;
    logic       busy, overrun, frame_err, parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_wr_cyc = 0;
    int consec = 0;
    logic prev_wr = 1'b0;
    int fcnt = 0;
    logic [7:0] mem [16];
    int start_cyc;
    int wr_base;

    uart_rx_fifo_wr #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .fifo_full(fifo_full), .err_clr(err_clr),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .busy(busy), .overrun(overrun),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    assign fifo_full = use_real ? (fcnt == 16) : force_full;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fcnt_clr) fcnt <= 0;
        else if (use_real && fifo_wr && !fifo_full) begin
            mem[fcnt[3:0]] <= fifo_din;
            fcnt <= fcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_wr) begin
            wr_count    <= wr_count + 1;
            last_wr_cyc <= cyc;
        end
        if (fifo_wr && prev_wr) consec <= consec + 1;
        prev_wr <= fifo_wr;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic sb);
        rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(C);
        end
        rxd = sb;
        tick(C);
    endtask

    initial begin
        // Reset
        tick(3);
        check("rst_wr", fifo_wr, 0);
        check("rst_din", fifo_din, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        check("rst_fe", frame_err, 0);
        check("rst_pe", parity_err, 0);
        rst = 1'b0;
        tick(3);

        // Frame 0xA5, FIFO not full
        start_cyc = cyc;
        wr_base = wr_count;
        send_frame(8'hA5, 1'b1);
        check("a5_busy_stop", busy, 1);
        check("a5_wr_early", fifo_wr, 0);
        tick(1);
        check("a5_wr", fifo_wr, 1);
        check("a5_din", fifo_din, 8'hA5);
        check("a5_busy_idle", busy, 0);
        tick(1);
        check("a5_wr_off", fifo_wr, 0);
        check("a5_din_hold", fifo_din, 8'hA5);
        check("a5_wr_count", wr_count - wr_base, 1);
        check("a5_latency", last_wr_cyc - start_cyc, 41);
        check("a5_ovr", overrun, 0);
        check("a5_fe", frame_err, 0);
        check("a5_pe", parity_err, 0);

        // One-cycle glitch is rejected in START
        wr_base = wr_count;
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(2);
        check("gl_busy", busy, 1);
        tick(10);
        check("gl_idle", busy, 0);
        check("gl_wr", wr_count - wr_base, 0);
        check("gl_fe", frame_err, 0);
        check("gl_ovr", overrun, 0);

        // FIFO full during 0x3C: dropped, overrun; err_clr in the set cycle loses
        wr_base = wr_count;
        force_full = 1'b1;
        send_frame(8'h3C, 1'b1);
        tick(1);
        check("full_wr", fifo_wr, 0);
        check("full_din", fifo_din, 8'hA5);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("full_ovr_set_wins", overrun, 1);
        check("full_wr_count", wr_count - wr_base, 0);
        check("full_din_hold", fifo_din, 8'hA5);
        force_full = 1'b0;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("full_ovr_clr", overrun, 0);

        // Stop bit 0 then line held low
        wr_base = wr_count;
        send_frame(8'hFF, 1'b0);
        tick(2);
        check("brk_fe", frame_err, 1);
        check("brk_busy", busy, 1);
        tick(48);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("brk_fe_clr", frame_err, 0);
        tick(50);
        check("brk_fe_once", frame_err, 0);
        check("brk_busy_hold", busy, 1);
        check("brk_wr", wr_count - wr_base, 0);
        rxd = 1'b1;
        tick(5);
        check("brk_idle", busy, 0);
        check("brk_wr_after", wr_count - wr_base, 0);

        // 17 back-to-back frames into a 16-deep FIFO
        fcnt_clr = 1'b1;
        tick(1);
        fcnt_clr = 1'b0;
        use_real = 1'b1;
        wr_base = wr_count;
        for (int f = 0; f < 17; f++) send_frame(8'(f), 1'b1);
        tick(2);
        check("b2b_writes", wr_count - wr_base, 16);
        check("b2b_fcnt", fcnt, 16);
        check("b2b_full", fifo_full, 1);
        check("b2b_ovr", overrun, 1);
        check("b2b_mem0", mem[0], 8'h00);
        check("b2b_mem7", mem[7], 8'h07);
        check("b2b_mem15", mem[15], 8'h0F);
        check("b2b_din", fifo_din, 8'h0F);
        check("b2b_consec", consec, 0);
        use_real = 1'b0;

        // Reset mid-DATA, then a clean frame
        wr_base = wr_count;
        rxd = 1'b0;
        tick(C);
        rxd = 1'b1;
        tick(3 * C);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick(1);
        check("mid_busy0", busy, 0);
        check("mid_wr0", fifo_wr, 0);
        check("mid_din0", fifo_din, 0);
        check("mid_ovr0", overrun, 0);
        check("mid_fe0", frame_err, 0);
        check("mid_pe0", parity_err, 0);
        rst = 1'b0;
        tick(10);
        check("mid_nowr", wr_count - wr_base, 0);
        send_frame(8'h5A, 1'b1);
        tick(1);
        check("post_wr", fifo_wr, 1);
        check("post_din", fifo_din, 8'h5A);
        tick(1);
        check("post_count", wr_count - wr_base, 1);
        check("post_consec", consec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
